// File: rtl/io_bridge64to256_fta.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge64to256_fta  (plus package io_bridge64to256_fta_pkg)
// Purpose  : Bridges a 64-bit FTA command initiator onto a 256-bit FTA target
//            bus. Requests are widened by lane placement. Responses are
//            narrowed by selecting the lane recorded when the request issued.
//            An outstanding-request FIFO holds {tid, lane} for each request.
// Ports    : clk_i   - clock, rising edge
//            rst_ni  - asynchronous active-low reset
//            s_req   - 64-bit initiator request            (in)
//            s_resp  - response to the 64-bit initiator    (out)
//            m_req   - request to the 256-bit target bus   (out)
//            m_resp  - response from the 256-bit target    (in)
// Params   : DEPTH   - outstanding FIFO depth, power of 2, 2..16
//            TIMEOUT - response timeout in clk_i cycles (>= 1)
// Config   : IOB_TIMEOUT_EN - when defined, adds the response timeout
//            counter and the TMO state. In the default build (macro not
//            defined), PEND is left only through a pop.
// Revision : 1.0 - initial release
// ============================================================================

package io_bridge64to256_fta_pkg;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  cmd;
    logic [1:0]  bte;
    logic [2:0]  cti;
    logic [7:0]  tid;
    logic [31:0] padr;
    logic [7:0]  sel;
    logic [63:0] dat;
  } fta_cmd_request64_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [3:0]   cmd;
    logic [1:0]   bte;
    logic [2:0]   cti;
    logic [7:0]   tid;
    logic [31:0]  padr;
    logic [31:0]  sel;
    logic [255:0] data1;
  } fta_cmd_request256_t;

  typedef struct packed {
    logic        ack;
    logic        rty;
    logic        err;
    logic        next;
    logic        stall;
    logic [7:0]  tid;
    logic [31:0] adr;
    logic [3:0]  pri;
    logic [63:0] dat;
  } fta_cmd_response64_t;

  typedef struct packed {
    logic         ack;
    logic         rty;
    logic         err;
    logic         next;
    logic         stall;
    logic [7:0]   tid;
    logic [31:0]  adr;
    logic [3:0]   pri;
    logic [255:0] dat;
  } fta_cmd_response256_t;

endpackage

module io_bridge64to256_fta
  import io_bridge64to256_fta_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  fta_cmd_request64_t   s_req,
  output fta_cmd_response64_t  s_resp,
  output fta_cmd_request256_t  m_req,
  input  fta_cmd_response256_t m_resp
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNW = PW + 1;

`ifdef IOB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_TMO  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_nxt;

  logic [7:0]          r_fifo_tid  [DEPTH];
  logic [1:0]          r_fifo_lane [DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic [CNW-1:0]      r_count;
  logic [CNW-1:0]      w_count_nxt;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_ack_pop;
  logic                w_tmo_pop;
  logic                w_pop;
  logic [1:0]          w_lane;
  logic [7:0]          w_head_tid;
  logic [1:0]          w_head_lane;
  logic                w_unused;

  fta_cmd_request256_t r_m_req;
  fta_cmd_response64_t r_s_resp;

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  assign w_full      = (r_count == CNW'(DEPTH));
  assign w_empty     = (r_count == '0);
  // Acceptance uses the registered full flag, so a pop in the same cycle
  // does not let a request in while full.
  assign w_push      = s_req.cyc & s_req.stb & ~w_full;
  assign w_ack_pop   = m_resp.ack & ~w_empty;
  assign w_pop       = w_ack_pop | w_tmo_pop;
  assign w_count_nxt = r_count + CNW'(w_push) - CNW'(w_pop);
  assign w_lane      = s_req.padr[4:3];
  assign w_head_tid  = r_fifo_tid[r_rptr];
  assign w_head_lane = r_fifo_lane[r_rptr];

  // Sub-lane address bits and the target stall are not needed by the bridge.
  assign w_unused    = ^{s_req.padr[2:0], m_resp.stall};

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_tid[r_wptr]  <= s_req.tid;
      r_fifo_lane[r_wptr] <= w_lane;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Response timeout
  // --------------------------------------------------------------------------
`ifdef IOB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_tmo_hit;

  // The counter holds the number of completed PEND cycles. When it is at
  // TIMEOUT-1 and this cycle is another pop-free PEND cycle, the count
  // reaches TIMEOUT and the FSM moves to TMO.
  assign w_tmo_hit = (r_tmo_cnt == TW'(TIMEOUT - 1));
  // A real ack in the TMO cycle takes priority over the timeout pop.
  assign w_tmo_pop = (r_state == ST_TMO) & ~w_ack_pop & ~w_empty;

  // Clearing whenever the FSM is outside PEND gives the clear-on-entry
  // behaviour.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= '0;
    end else if (w_pop || (r_state != ST_PEND)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  assign w_tmo_pop = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_count_nxt == '0) begin
          w_state_nxt = ST_IDLE;
        end
`ifdef IOB_TIMEOUT_EN
        else if (!w_pop && w_tmo_hit) begin
          w_state_nxt = ST_TMO;
        end
`endif
      end
`ifdef IOB_TIMEOUT_EN
      ST_TMO: begin
        w_state_nxt = (w_count_nxt == '0) ? ST_IDLE : ST_PEND;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request path: widen onto the lane selected by padr[4:3]
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_m_req      <= '0;
      r_m_req.padr <= 32'hFFFF_FFFF;
    end else if (w_push) begin
      r_m_req.cyc   <= 1'b1;
      r_m_req.stb   <= s_req.stb;
      r_m_req.we    <= s_req.we;
      r_m_req.cmd   <= s_req.cmd;
      r_m_req.bte   <= s_req.bte;
      r_m_req.cti   <= s_req.cti;
      r_m_req.tid   <= s_req.tid;
      r_m_req.padr  <= {s_req.padr[31:5], 5'd0};
      r_m_req.sel   <= 32'(s_req.sel) << {w_lane, 3'b000};
      r_m_req.data1 <= {4{s_req.dat}};
    end else begin
      r_m_req      <= '0;
      r_m_req.padr <= 32'hFFFF_FFFF;
    end
  end

  assign m_req = r_m_req;

  // --------------------------------------------------------------------------
  // Response path: narrow by the head lane, flag tid mismatch, report timeout
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s_resp <= '0;
    end else begin
      r_s_resp      <= '0;
      r_s_resp.rty  <= m_resp.rty;
      r_s_resp.next <= m_resp.next;
      r_s_resp.err  <= m_resp.err;
      if (w_ack_pop) begin
        r_s_resp.ack <= 1'b1;
        r_s_resp.dat <= m_resp.dat[{w_head_lane, 6'd0} +: 64];
        r_s_resp.tid <= m_resp.tid;
        r_s_resp.adr <= m_resp.adr;
        r_s_resp.pri <= m_resp.pri;
        r_s_resp.err <= m_resp.err | (m_resp.tid != w_head_tid);
      end else if (w_tmo_pop) begin
        r_s_resp.err <= 1'b1;
        r_s_resp.tid <= w_head_tid;
      end
    end
  end

  // Stall follows the live FIFO occupancy, so it drops the cycle after the
  // pop that frees an entry.
  always_comb begin
    s_resp       = r_s_resp;
    s_resp.stall = w_full;
  end

endmodule

`default_nettype wire

// File: tb/tb_io_bridge64to256_fta.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bridge64to256_fta
// Purpose  : Self-checking bench for io_bridge64to256_fta. A queue-based
//            model predicts m_req/s_resp every cycle; directed vectors add
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bridge64to256_fta;
  import io_bridge64to256_fta_pkg::*;

  localparam int TB_DEPTH   = 4;
  localparam int TB_TIMEOUT = 8;

  logic                 clk_i;
  logic                 rst_ni;
  fta_cmd_request64_t   s_req;
  fta_cmd_response64_t  s_resp;
  fta_cmd_request256_t  m_req;
  fta_cmd_response256_t m_resp;

  int n_pass;
  int n_total;

  io_bridge64to256_fta #(
    .DEPTH   (TB_DEPTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .s_req  (s_req),
    .s_resp (s_resp),
    .m_req  (m_req),
    .m_resp (m_resp)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // --------------------------------------------------------------------------
  // Model: queue of outstanding {tid, lane}; timeout fires TIMEOUT+1 cycles
  // after the last pop or the push into an empty queue.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] tid;
    int         lane;
  } ent_t;

  ent_t                q[$];
  int                  cyc_no = 0;
  int                  last_event = 0;
  fta_cmd_request256_t exp_m;
  fta_cmd_response64_t exp_s;

  always @(posedge clk_i) begin
    logic         accept;
    logic         ack_pop;
    logic         tmo;
    logic         was_empty;
    logic [255:0] tmp;
    int           lane;
    cyc_no++;
    exp_m      = '0;
    exp_m.padr = 32'hFFFF_FFFF;
    exp_s      = '0;
    if (!rst_ni) begin
      q.delete();
    end else begin
      was_empty = (q.size() == 0);
      accept    = s_req.cyc && s_req.stb && (q.size() != TB_DEPTH);
      ack_pop   = m_resp.ack && (q.size() > 0);
`ifdef IOB_TIMEOUT_EN
      tmo = (q.size() > 0) && !ack_pop && (cyc_no == last_event + TB_TIMEOUT + 1);
`else
      tmo = 1'b0;
`endif
      if (accept) begin
        lane        = int'(s_req.padr[4:3]);
        exp_m.cyc   = 1'b1;
        exp_m.stb   = s_req.stb;
        exp_m.we    = s_req.we;
        exp_m.cmd   = s_req.cmd;
        exp_m.bte   = s_req.bte;
        exp_m.cti   = s_req.cti;
        exp_m.tid   = s_req.tid;
        exp_m.padr  = s_req.padr & 32'hFFFF_FFE0;
        exp_m.sel   = 32'(s_req.sel) << (8 * lane);
        exp_m.data1 = {s_req.dat, s_req.dat, s_req.dat, s_req.dat};
      end
      exp_s.rty  = m_resp.rty;
      exp_s.next = m_resp.next;
      exp_s.err  = m_resp.err;
      if (ack_pop) begin
        tmp       = m_resp.dat >> (64 * q[0].lane);
        exp_s.ack = 1'b1;
        exp_s.dat = tmp[63:0];
        exp_s.tid = m_resp.tid;
        exp_s.adr = m_resp.adr;
        exp_s.pri = m_resp.pri;
        exp_s.err = m_resp.err || (m_resp.tid != q[0].tid);
      end else if (tmo) begin
        exp_s.err = 1'b1;
        exp_s.tid = q[0].tid;
      end
      if (ack_pop || tmo) begin
        void'(q.pop_front());
        last_event = cyc_no;
      end
      if (accept) begin
        q.push_back('{tid: s_req.tid, lane: int'(s_req.padr[4:3])});
        if (was_empty) last_event = cyc_no;
      end
      exp_s.stall = (q.size() == TB_DEPTH);
    end
    #1;
    n_total++;
    if (m_req !== exp_m)
      $display("FAIL m_req cyc %0d: got %h expected %h", cyc_no, m_req, exp_m);
    else
      n_pass++;
    n_total++;
    if (s_resp !== exp_s)
      $display("FAIL s_resp cyc %0d: got %h expected %h", cyc_no, s_resp, exp_s);
    else
      n_pass++;
  end

  // --------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
    n_total++;
    if (act !== expv) $display("FAIL %s: got %h expected %h", nm, act, expv);
    else              n_pass++;
  endtask

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle();
    s_req  = '0;
    m_resp = '0;
  endtask

  task automatic send_req(input logic we, input logic [31:0] padr, input logic [7:0] sel,
                          input logic [7:0] tid, input logic [63:0] dat);
    s_req      = '0;
    s_req.cyc  = 1'b1;
    s_req.stb  = 1'b1;
    s_req.we   = we;
    s_req.cmd  = 4'h3;
    s_req.cti  = 3'd1;
    s_req.padr = padr;
    s_req.sel  = sel;
    s_req.tid  = tid;
    s_req.dat  = dat;
  endtask

  task automatic send_ack(input logic [7:0] tid, input logic [255:0] dat);
    m_resp     = '0;
    m_resp.ack = 1'b1;
    m_resp.tid = tid;
    m_resp.adr = 32'h0000_1000;
    m_resp.pri = 4'h2;
    m_resp.dat = dat;
  endtask

  initial begin
    int k;
    n_pass  = 0;
    n_total = 0;
    rst_ni  = 1'b0;
    idle();
    repeat (3) step();
    chk("rst_m_padr", m_req.padr, 32'hFFFF_FFFF);
    chk("rst_m_cyc", m_req.cyc, 1'b0);
    chk("rst_s_resp", s_resp, '0);
    rst_ni = 1'b1;
    step();

    // Read on lane 3
    send_req(1'b0, 32'h0000_1018, 8'h0F, 8'd5, 64'h0);
    step();
    chk("rd_cyc", m_req.cyc, 1'b1);
    chk("rd_padr", m_req.padr, 32'h0000_1000);
    chk("rd_sel", m_req.sel, 32'h0F00_0000);
    chk("rd_tid", m_req.tid, 8'd5);
    idle();
    step();
    chk("idle_cyc", m_req.cyc, 1'b0);
    chk("idle_padr", m_req.padr, 32'hFFFF_FFFF);
    send_ack(8'd5, {64'h1122_3344_5566_7788, 64'hAAAA_0000_0000_0002,
                    64'hBBBB_0000_0000_0001, 64'hCCCC_0000_0000_0000});
    step();
    chk("rd_ack", s_resp.ack, 1'b1);
    chk("rd_dat", s_resp.dat, 64'h1122_3344_5566_7788);
    chk("rd_tid_resp", s_resp.tid, 8'd5);
    chk("rd_err", s_resp.err, 1'b0);
    idle();
    step();
    chk("rd_ack_done", s_resp.ack, 1'b0);

    // Write on lane 1, then push and pop in the same cycle
    send_req(1'b1, 32'h0000_0008, 8'hFF, 8'd1, 64'hA5A5_A5A5_A5A5_A5A5);
    step();
    chk("wr_sel", m_req.sel, 32'h0000_FF00);
    chk("wr_data1", m_req.data1, {4{64'hA5A5_A5A5_A5A5_A5A5}});
    chk("wr_we", m_req.we, 1'b1);
    chk("wr_padr", m_req.padr, 32'h0000_0000);
    send_req(1'b0, 32'h0000_0010, 8'hFF, 8'd2, 64'h0);
    send_ack(8'd1, {64'h0, 64'h0, 64'h0123_4567_89AB_CDEF, 64'h0});
    step();
    chk("pp_dat", s_resp.dat, 64'h0123_4567_89AB_CDEF);
    chk("pp_sel", m_req.sel, 32'h00FF_0000);
    idle();
    send_ack(8'd2, {64'h0, 64'h7777_0000_0000_0007, 64'h0, 64'h0});
    step();
    chk("pp2_dat", s_resp.dat, 64'h7777_0000_0000_0007);
    idle();
    step();

    // Back-pressure
    for (int i = 0; i < TB_DEPTH; i++) begin
      send_req(1'b0, 32'h0000_0100 + 32'(i * 8), 8'h01, 8'(10 + i), 64'(i));
      step();
    end
    chk("bp_stall", s_resp.stall, 1'b1);
    send_req(1'b0, 32'h0000_0200, 8'h01, 8'd14, 64'h0);
    step();
    chk("bp_5th_cyc", m_req.cyc, 1'b0);
    send_ack(8'd10, 256'h1);
    step();
    chk("bp_popfull_cyc", m_req.cyc, 1'b0);
    chk("bp_stall_rel", s_resp.stall, 1'b0);
    m_resp = '0;
    step();
    chk("bp_5th_acc", m_req.cyc, 1'b1);
    chk("bp_5th_tid", m_req.tid, 8'd14);
    idle();
    send_ack(8'd99, 256'h0);
    step();
    chk("mis_ack", s_resp.ack, 1'b1);
    chk("mis_err", s_resp.err, 1'b1);
    for (int i = 12; i <= 14; i++) begin
      send_ack(8'(i), 256'(i));
      step();
    end
    idle();
    step();

    // Ack on empty FIFO, and plain rty/err pass-through
    send_ack(8'd7, 256'h5);
    step();
    chk("drop_ack", s_resp.ack, 1'b0);
    m_resp     = '0;
    m_resp.rty = 1'b1;
    m_resp.err = 1'b1;
    step();
    chk("pass_rty", s_resp.rty, 1'b1);
    chk("pass_err", s_resp.err, 1'b1);
    chk("pass_ack", s_resp.ack, 1'b0);
    idle();
    step();

    // Reset with three pending requests
    for (int i = 0; i < 3; i++) begin
      send_req(1'b0, 32'h0000_0300, 8'h01, 8'(20 + i), 64'h0);
      step();
    end
    idle();
    rst_ni = 1'b0;
    #1;
    chk("mrst_m_cyc", m_req.cyc, 1'b0);
    chk("mrst_m_padr", m_req.padr, 32'hFFFF_FFFF);
    chk("mrst_s_resp", s_resp, '0);
    step();
    step();
    rst_ni = 1'b1;
    step();
    send_ack(8'd20, 256'h9);
    step();
    chk("mrst_late_ack", s_resp.ack, 1'b0);
    idle();
    step();

`ifdef IOB_TIMEOUT_EN
    // Timeout
    send_req(1'b0, 32'h0000_0400, 8'h01, 8'h33, 64'h0);
    step();
    idle();
    k = 0;
    while (k < 40) begin
      step();
      k++;
      if (s_resp.err === 1'b1) break;
    end
    chk("tmo_latency", 256'(k), 256'(TB_TIMEOUT + 1));
    chk("tmo_tid", s_resp.tid, 8'h33);
    chk("tmo_ack", s_resp.ack, 1'b0);
    chk("tmo_dat", s_resp.dat, 64'h0);
    step();
    send_ack(8'h33, 256'h1);
    step();
    chk("tmo_late_ack", s_resp.ack, 1'b0);
    idle();
`endif

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
